// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
//
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-low reset
//   start_i   accept an operation while idle
//   flush_i   abort the in-flight operation (wins over start_i in idle)
//   op_i      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   busy_o    operation in progress
//   done_o    one-cycle pulse, result_o valid
//   result_o  result, held until the next completion
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2    = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  // Multiplicand for multiplies, divisor for divides.
  logic [XLEN-1:0]   opnd_q;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] p_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;

  logic              accept, complete;

  // ---------------- operand conditioning at accept ----------------
  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val;

  always_comb begin
    is_div   = op_i[2];
    a_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    b_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    a_mag    = a_neg ? (~rs1_i + ONE) : rs1_i;
    b_mag    = b_neg ? (~rs2_i + ONE) : rs2_i;

    div_by_zero = is_div && (rs2_i == '0);
    div_ovf     = is_div && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
    special     = div_by_zero | div_ovf;
    // op_i[1] distinguishes remainder from quotient among the divide ops.
    if (div_by_zero) special_val = op_i[1] ? rs1_i : '1;
    else             special_val = op_i[1] ? '0    : rs1_i;
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, p_q[XLEN-1:1]};

    div_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // A borrow out of the trial subtraction means the divisor did not fit:
    // keep the shifted remainder and shift in a zero quotient bit.
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  p_q[XLEN-2:0], 1'b1};
  end

  // ---------------- sign correction ----------------
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_rem, div_res, final_res;

  always_comb begin
    // The whole double-width product is negated so the high half sees the
    // borrow from the low half.
    prod      = neg_q ? (~p_q + ONE2) : p_q;
    quo_rem   = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
    div_res   = neg_q ? (~quo_rem + ONE) : quo_rem;
    if (op_q[2])              final_res = div_res;
    else if (op_q[1:0] == 2'b00) final_res = prod[XLEN-1:0];
    else                      final_res = prod[2*XLEN-1:XLEN];
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept  = 1'b1;
          state_d = special ? FINISH : CALC;
        end
      end
      CALC: begin
        if (flush_i)                state_d = IDLE;
        else if (cnt_q == CW'(1))   state_d = FINISH;
      end
      FINISH: begin
        state_d  = IDLE;
        complete = !flush_i;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q     <= '0;
      opnd_q   <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        op_q  <= op_i;
        cnt_q <= CW'(XLEN);
        if (special) begin
          // Both halves carry the answer so the normal quotient/remainder
          // select in FINISH picks it up unchanged.
          opnd_q <= '0;
          p_q    <= {special_val, special_val};
          neg_q  <= 1'b0;
        end else if (is_div) begin
          opnd_q <= b_mag;
          p_q    <= {{XLEN{1'b0}}, a_mag};
          neg_q  <= op_i[1] ? a_neg : (a_neg ^ b_neg);
        end else begin
          opnd_q <= a_mag;
          p_q    <= {{XLEN{1'b0}}, b_mag};
          neg_q  <= a_neg ^ b_neg;
        end
      end else if (state_q == CALC) begin
        p_q   <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q - CW'(1);
      end
      if (complete) begin
        result_o <= final_res;
        done_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (XLEN=32 and XLEN=8)
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, res;
  logic        busy, done;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        busy8, done8;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush), .op_i(op),
    .rs1_i(a), .rs2_i(b), .busy_o(busy), .done_o(done), .result_o(res)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .flush_i(flush8), .op_i(op8),
    .rs1_i(a8), .rs2_i(b8), .busy_o(busy8), .done_o(done8), .result_o(res8)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  logic [31:0] last32 = '0;

  int total = 0;
  int bad   = 0;

  string names[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Reference model: plain integer arithmetic on w-bit operands.
  function automatic logic [31:0] model(input logic [2:0] fop, input logic [31:0] fa,
                                        input logic [31:0] fb, input int w);
    logic [63:0] mask, ua, ub, r;
    longint      sa, sb, minv;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, fa} & mask;
    ub   = {32'd0, fb} & mask;
    sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    minv = -(longint'(1) << (w - 1));
    case (fop)
      3'd0: r = ua * ub;
      3'd1: r = 64'(sa * sb) >> w;
      3'd2: r = 64'(sa * longint'(ub)) >> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: if (ub == 0) r = '1;
            else if (sa == minv && sb == -1) r = ua;
            else r = 64'(sa / sb);
      3'd5: r = (ub == 0) ? '1 : ua / ub;
      3'd6: if (ub == 0) r = ua;
            else if (sa == minv && sb == -1) r = '0;
            else r = 64'(sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int latency(input logic [2:0] fop, input logic [31:0] fa,
                                 input logic [31:0] fb, input int w);
    logic [63:0] mask, ua, ub;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, fa} & mask;
    ub   = {32'd0, fb} & mask;
    if (fop[2] && (ub == 0 || (!fop[0] && ua == (64'd1 << (w - 1)) && ub == mask)))
      return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'($urandom_range(0, 20));
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q32.size() == 0) begin
        check("unexpected_done32", 32'd1, 32'd0);
      end else begin
        e = q32.pop_front();
        check({e.name, "_result"}, res, e.res);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        last32 = e.res;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check({e.name, "_result8"}, {24'd0, res8}, e.res);
        check({e.name, "_cycle8"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns 1 ns after the accept edge.
  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, output int acc);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    acc = cyc;
    if (push) begin
      e.res  = model(o, x, y, 32);
      e.cyc  = acc + latency(o, x, y, 32);
      e.name = names[o];
      q32.push_back(e);
    end
  endtask

  task automatic wait_idle32();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) fail_now("wait_idle32");
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    #1;
    start8 = 1'b0; op8 = 3'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    e.res  = model(o, {24'd0, x}, {24'd0, y}, 8);
    e.cyc  = cyc + latency(o, {24'd0, x}, {24'd0, y}, 8);
    e.name = names[o];
    q8.push_back(e);
  endtask

  task automatic wait_idle8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy8 && n < 30);
    if (busy8) fail_now("wait_idle8");
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t dir[13] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD},
    '{3'd1, 32'h8000_0000,  32'h8000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd2, 32'hFFFF_FFFF,  32'd2},
    '{3'd5, 32'd100,        32'd7},
    '{3'd7, 32'd100,        32'd7},
    '{3'd4, 32'hFFFF_FFF9,  32'd2},
    '{3'd6, 32'hFFFF_FFF9,  32'd2},
    '{3'd4, 32'd5,          32'd0},
    '{3'd7, 32'd5,          32'd0},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd5, 32'd5,          32'd0}
  };

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    logic [31:0] prior;
    rst_n = 1'b0;
    start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", res, 32'd0);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_result8", {24'd0, res8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, each started in the done cycle of the previous one.
    foreach (dir[i]) begin
      issue32(dir[i].o, dir[i].x, dir[i].y, 1'b1, acc);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_idle32();
    end

    // Start while busy is ignored.
    issue32(3'd0, 32'd1234, 32'd5678, 1'b1, acc);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd9; b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_ignores_start", {31'd0, busy}, 32'd1);
    wait_idle32();

    // Flush in CALC.
    @(negedge clk);
    prior = last32;
    issue32(3'd5, 32'd100, 32'd7, 1'b0, acc);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_busy", {31'd0, busy}, 32'd0);
    check("flush_calc_result", res, prior);
    @(negedge clk);
    issue32(3'd5, 32'd1000, 32'd9, 1'b1, acc);
    wait_idle32();

    // Flush in FINISH suppresses the completion.
    @(negedge clk);
    prior = last32;
    issue32(3'd0, 32'd3, 32'd5, 1'b0, acc);
    repeat (33) @(negedge clk);
    check("finish_state_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_finish_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("flush_finish_result", res, prior);

    // Start together with flush while idle: nothing accepted.
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Random operations.
    for (int i = 0; i < 60; i++) begin
      issue32(3'($urandom_range(0, 7)), pick(), pick(), 1'b1, acc);
      wait_idle32();
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    issue32(3'd0, 32'd77, 32'd88, 1'b0, acc);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_done", {31'd0, done}, 32'd0);
    check("async_reset_result", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    // XLEN = 8 instance.
    issue8(3'd0, 8'h0F, 8'h0F);
    wait_idle8();
    issue8(3'd3, 8'h0F, 8'h0F);
    wait_idle8();
    issue8(3'd4, 8'h80, 8'hFF);
    wait_idle8();
    for (int i = 0; i < 40; i++) begin
      issue8(3'($urandom_range(0, 7)), pick8(), pick8());
      wait_idle8();
    end

    repeat (3) @(negedge clk);
    check("leftover32", 32'(q32.size()), 32'd0);
    check("leftover8", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
